// File: rtl/axi_lite_region_router.sv
// AXI4-Lite router: one upstream master fans out to NB_SLAVE slaves chosen by
// runtime-programmable address regions; unmapped accesses get DECERR and are counted.
module axi_lite_region_router #(
  parameter int NB_SLAVE   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0]   start_addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0]   end_addr_i,
  input  logic [NB_SLAVE-1:0]              region_en_i,
  output logic [CNT_WIDTH-1:0]             decerr_cnt_o,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0]   m_awaddr,
  output logic [NB_SLAVE-1:0]              m_awvalid,
  input  logic [NB_SLAVE-1:0]              m_awready,
  output logic [NB_SLAVE*DATA_WIDTH-1:0]   m_wdata,
  output logic [NB_SLAVE*DATA_WIDTH/8-1:0] m_wstrb,
  output logic [NB_SLAVE-1:0]              m_wvalid,
  input  logic [NB_SLAVE-1:0]              m_wready,
  input  logic [NB_SLAVE*2-1:0]            m_bresp,
  input  logic [NB_SLAVE-1:0]              m_bvalid,
  output logic [NB_SLAVE-1:0]              m_bready,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0]   m_araddr,
  output logic [NB_SLAVE-1:0]              m_arvalid,
  input  logic [NB_SLAVE-1:0]              m_arready,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0]   m_rdata,
  input  logic [NB_SLAVE*2-1:0]            m_rresp,
  input  logic [NB_SLAVE-1:0]              m_rvalid,
  output logic [NB_SLAVE-1:0]              m_rready
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_WIDTH  = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;

  r_state_t              r_state_reg;
  logic [ADDR_WIDTH-1:0] r_addr_reg;
  logic [SEL_WIDTH-1:0]  r_sel_reg;
  w_state_t              w_state_reg;
  logic [ADDR_WIDTH-1:0] w_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_WIDTH-1:0] w_strb_reg;
  logic [SEL_WIDTH-1:0]  w_sel_reg;
  logic                  aw_sent_reg, w_sent_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;

  logic [NB_SLAVE-1:0]   ar_hit, aw_hit;
  logic [SEL_WIDTH-1:0]  ar_sel, aw_sel;
  logic                  aw_done, w_done, rd_err_hs, wr_err_hs;
  logic [CNT_WIDTH:0]    cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NB_SLAVE; gi++) begin : g_slice
      assign ar_hit[gi] = region_en_i[gi]
                       && (s_araddr >= start_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH])
                       && (s_araddr <= end_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      assign aw_hit[gi] = region_en_i[gi]
                       && (s_awaddr >= start_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH])
                       && (s_awaddr <= end_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      assign m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_addr_reg;
      assign m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_addr_reg;
      assign m_wdata[gi*DATA_WIDTH +: DATA_WIDTH]  = w_data_reg;
      assign m_wstrb[gi*STRB_WIDTH +: STRB_WIDTH]  = w_strb_reg;
    end
  endgenerate

  // Scan downward so the lowest hitting region is the one left standing.
  always_comb begin
    ar_sel = '0;
    aw_sel = '0;
    for (int i = NB_SLAVE - 1; i >= 0; i--) begin
      if (ar_hit[i]) ar_sel = SEL_WIDTH'(i);
      if (aw_hit[i]) aw_sel = SEL_WIDTH'(i);
    end
  end

  assign s_arready = rst_n && (r_state_reg == R_IDLE);
  assign s_awready = rst_n && (w_state_reg == W_IDLE) && s_awvalid && s_wvalid;
  assign s_wready  = s_awready;
  assign aw_done   = aw_sent_reg || m_awready[w_sel_reg];
  assign w_done    = w_sent_reg || m_wready[w_sel_reg];
  assign rd_err_hs = (r_state_reg == R_ERR) && s_rready;
  assign wr_err_hs = (w_state_reg == W_ERR) && s_bready;
  assign cnt_next  = {1'b0, cnt_reg} + {{(CNT_WIDTH-1){1'b0}}, ({1'b0, rd_err_hs} + {1'b0, wr_err_hs})};
  assign decerr_cnt_o = cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_sel_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: if (s_arvalid) begin
          r_addr_reg  <= s_araddr;
          r_sel_reg   <= ar_sel;
          r_state_reg <= (|ar_hit) ? R_ADDR : R_ERR;
        end
        R_ADDR: if (m_arready[r_sel_reg]) r_state_reg <= R_DATA;
        R_DATA: if (m_rvalid[r_sel_reg] && s_rready) r_state_reg <= R_IDLE;
        R_ERR:  if (s_rready) r_state_reg <= R_IDLE;
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      w_addr_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      w_sel_reg   <= '0;
      aw_sent_reg <= 1'b0;
      w_sent_reg  <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: if (s_awvalid && s_wvalid) begin
          w_addr_reg  <= s_awaddr;
          w_data_reg  <= s_wdata;
          w_strb_reg  <= s_wstrb;
          w_sel_reg   <= aw_sel;
          aw_sent_reg <= 1'b0;
          w_sent_reg  <= 1'b0;
          w_state_reg <= (|aw_hit) ? W_FWD : W_ERR;
        end
        // AW and W may complete in either order or together.
        W_FWD: if (aw_done && w_done) begin
          aw_sent_reg <= 1'b0;
          w_sent_reg  <= 1'b0;
          w_state_reg <= W_RESP;
        end else begin
          aw_sent_reg <= aw_done;
          w_sent_reg  <= w_done;
        end
        W_RESP: if (m_bvalid[w_sel_reg] && s_bready) w_state_reg <= W_IDLE;
        W_ERR:  if (s_bready) w_state_reg <= W_IDLE;
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_reg <= '0;
    else if (cnt_next[CNT_WIDTH]) cnt_reg <= '1;
    else cnt_reg <= cnt_next[CNT_WIDTH-1:0];
  end

  always_comb begin
    m_arvalid = '0;
    m_rready  = '0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    if (r_state_reg == R_ADDR) m_arvalid[r_sel_reg] = 1'b1;
    if (r_state_reg == R_DATA) begin
      m_rready[r_sel_reg] = s_rready;
      s_rvalid = m_rvalid[r_sel_reg];
      s_rdata  = m_rdata[r_sel_reg*DATA_WIDTH +: DATA_WIDTH];
      s_rresp  = m_rresp[r_sel_reg*2 +: 2];
    end
    if (r_state_reg == R_ERR) begin
      s_rvalid = 1'b1;
      s_rresp  = 2'b11;
    end
  end

  always_comb begin
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    if (w_state_reg == W_FWD) begin
      m_awvalid[w_sel_reg] = !aw_sent_reg;
      m_wvalid[w_sel_reg]  = !w_sent_reg;
    end
    if (w_state_reg == W_RESP) begin
      m_bready[w_sel_reg] = s_bready;
      s_bvalid = m_bvalid[w_sel_reg];
      s_bresp  = m_bresp[w_sel_reg*2 +: 2];
    end
    if (w_state_reg == W_ERR) begin
      s_bvalid = 1'b1;
      s_bresp  = 2'b11;
    end
  end
endmodule

// File: tb/tb_axi_lite_region_router.sv
// Bench for axi_lite_region_router: transaction-level model checked every cycle,
// behavioural slaves with per-slave ready latencies, and directed scenarios.
module tb_axi_lite_region_router;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [NB*AW-1:0] start_addr, end_addr;
  logic [NB-1:0] region_en;
  logic [CW-1:0] decerr_cnt;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NB*AW-1:0] m_awaddr, m_araddr;
  logic [NB-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NB-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NB*DW-1:0] m_wdata, m_rdata;
  logic [NB*DW/8-1:0] m_wstrb;
  logic [NB*2-1:0] m_bresp, m_rresp;

  axi_lite_region_router #(.NB_SLAVE(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_addr_i(start_addr), .end_addr_i(end_addr),
    .region_en_i(region_en), .decerr_cnt_o(decerr_cnt),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // Address map, driven onto the packed DUT ports.
  logic [AW-1:0] map_start [NB];
  logic [AW-1:0] map_end [NB];
  logic map_en [NB];
  always_comb begin
    start_addr = '0;
    end_addr = '0;
    region_en = '0;
    for (int i = 0; i < NB; i++) begin
      start_addr[i*AW +: AW] = map_start[i];
      end_addr[i*AW +: AW] = map_end[i];
      region_en[i] = map_en[i];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NB; i++)
      if (map_en[i] && a >= map_start[i] && a <= map_end[i]) return i;
    return -1;
  endfunction

  function automatic logic [NB-1:0] onehot(input int t);
    logic [NB-1:0] r;
    r = '0;
    if (t >= 0) r[t] = 1'b1;
    return r;
  endfunction

  // Behavioural slaves
  logic [DW-1:0] rd_data [NB] = '{32'h0000_1000, 32'hDEADBEEF, 32'h2222_2222, 32'h3333_3333};
  int aw_lat [NB] = '{0, 0, 0, 0};
  int w_lat [NB] = '{0, 0, 0, 0};
  int aw_cnt [NB], w_cnt [NB];
  bit aw_got [NB], w_got [NB], rd_pend [NB];

  initial begin
    m_arready = '0; m_awready = '0; m_wready = '0; m_rvalid = '0; m_bvalid = '0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NB; i++) begin
        m_arready[i] = 1'b1;
        m_awready[i] = !aw_got[i] && aw_cnt[i] >= aw_lat[i];
        m_wready[i] = !w_got[i] && w_cnt[i] >= w_lat[i];
        m_rvalid[i] = rd_pend[i];
        m_rdata[i*DW +: DW] = rd_data[i];
        m_bvalid[i] = aw_got[i] && w_got[i];
      end
    end
  end

  // Transaction-level model of the router
  bit rd_busy, rd_adone, wr_busy, wr_adone, wr_wdone;
  int rd_tgt, wr_tgt, model_cnt, cyc, aw_hs_cyc, w_hs_cyc;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW/8-1:0] wr_strb;

  always @(negedge clk) begin
    logic [NB-1:0] e_arv, e_rrdy, e_awv, e_wv, e_brdy;
    logic e_arrdy, e_awrdy, e_rv, e_bv;
    int inc;
    cyc++;
    e_arv = (rd_busy && rd_tgt >= 0 && !rd_adone) ? onehot(rd_tgt) : '0;
    e_rrdy = (rd_busy && rd_tgt >= 0 && rd_adone && s_rready) ? onehot(rd_tgt) : '0;
    e_rv = 1'b0;
    if (rd_busy && rd_tgt < 0) e_rv = 1'b1;
    else if (rd_busy && rd_adone) e_rv = m_rvalid[rd_tgt];
    e_arrdy = rst_n && !rd_busy;
    e_awv = (wr_busy && wr_tgt >= 0 && !wr_adone) ? onehot(wr_tgt) : '0;
    e_wv = (wr_busy && wr_tgt >= 0 && !wr_wdone) ? onehot(wr_tgt) : '0;
    e_brdy = (wr_busy && wr_tgt >= 0 && wr_adone && wr_wdone && s_bready) ? onehot(wr_tgt) : '0;
    e_bv = 1'b0;
    if (wr_busy && wr_tgt < 0) e_bv = 1'b1;
    else if (wr_busy && wr_adone && wr_wdone) e_bv = m_bvalid[wr_tgt];
    e_awrdy = rst_n && !wr_busy && s_awvalid && s_wvalid;

    chk("m_arvalid", m_arvalid, e_arv);
    chk("m_rready", m_rready, e_rrdy);
    chk("s_rvalid", s_rvalid, e_rv);
    chk("s_arready", s_arready, e_arrdy);
    chk("m_awvalid", m_awvalid, e_awv);
    chk("m_wvalid", m_wvalid, e_wv);
    chk("m_bready", m_bready, e_brdy);
    chk("s_bvalid", s_bvalid, e_bv);
    chk("s_awready", s_awready, e_awrdy);
    chk("s_wready", s_wready, e_awrdy);
    chk("decerr_cnt", decerr_cnt, model_cnt);
    if (e_rv) begin
      chk("s_rdata", s_rdata, (rd_tgt < 0) ? 32'h0 : rd_data[rd_tgt]);
      chk("s_rresp", s_rresp, (rd_tgt < 0) ? 2'b11 : 2'b00);
    end
    if (e_bv) chk("s_bresp", s_bresp, (wr_tgt < 0) ? 2'b11 : 2'b00);
    if (|e_arv) chk("m_araddr", m_araddr[rd_tgt*AW +: AW], rd_addr);
    if (|e_awv) chk("m_awaddr", m_awaddr[wr_tgt*AW +: AW], wr_addr);
    if (|e_wv) begin
      chk("m_wdata", m_wdata[wr_tgt*DW +: DW], wr_data);
      chk("m_wstrb", m_wstrb[wr_tgt*DW/8 +: DW/8], wr_strb);
    end

    if (!rst_n) begin
      rd_busy = 0; wr_busy = 0; model_cnt = 0;
      for (int i = 0; i < NB; i++) begin
        aw_got[i] = 0; w_got[i] = 0; rd_pend[i] = 0; aw_cnt[i] = 0; w_cnt[i] = 0;
      end
    end else begin
      inc = 0;
      if (!rd_busy) begin
        if (s_arvalid && e_arrdy) begin
          rd_busy = 1; rd_tgt = decode(s_araddr); rd_addr = s_araddr; rd_adone = 0;
        end
      end else begin
        if (|e_arv && m_arready[rd_tgt]) rd_adone = 1;
        if (e_rv && s_rready) begin
          rd_busy = 0;
          if (rd_tgt < 0) inc++;
        end
      end
      if (!wr_busy) begin
        if (e_awrdy) begin
          wr_busy = 1; wr_tgt = decode(s_awaddr); wr_addr = s_awaddr;
          wr_data = s_wdata; wr_strb = s_wstrb; wr_adone = 0; wr_wdone = 0;
        end
      end else begin
        if (|e_awv && m_awready[wr_tgt]) begin wr_adone = 1; aw_hs_cyc = cyc; end
        if (|e_wv && m_wready[wr_tgt]) begin wr_wdone = 1; w_hs_cyc = cyc; end
        if (e_bv && s_bready) begin
          wr_busy = 0;
          if (wr_tgt < 0) inc++;
        end
      end
      model_cnt = (model_cnt + inc > 255) ? 255 : model_cnt + inc;
      for (int i = 0; i < NB; i++) begin
        if (m_awvalid[i]) begin
          if (m_awready[i]) aw_got[i] = 1; else aw_cnt[i]++;
        end
        if (m_wvalid[i]) begin
          if (m_wready[i]) w_got[i] = 1; else w_cnt[i]++;
        end
        if (m_arvalid[i] && m_arready[i]) rd_pend[i] = 1;
        if (m_rvalid[i] && m_rready[i]) rd_pend[i] = 0;
        if (m_bvalid[i] && m_bready[i]) begin
          aw_got[i] = 0; w_got[i] = 0; aw_cnt[i] = 0; w_cnt[i] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_start(input logic [AW-1:0] a);
    bit ok = 0;
    s_araddr = a; s_arvalid = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = s_arready;
      step();
    end
    s_arvalid = 0;
    chk("ar_accept", ok, 1);
  endtask

  task automatic rd_finish(output logic [DW-1:0] d, output logic [1:0] r, output int w);
    bit ok = 0;
    s_rready = 1; w = 0; d = '0; r = '0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      w++;
      if (s_rvalid) begin ok = 1; d = s_rdata; r = s_rresp; end
      step();
    end
    chk("r_response", ok, 1);
  endtask

  task automatic wr_start(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bit ok = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = s_awready;
      step();
    end
    s_awvalid = 0; s_wvalid = 0;
    chk("aw_accept", ok, 1);
  endtask

  task automatic wr_finish(output logic [1:0] r);
    bit ok = 0;
    s_bready = 1; r = '0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (s_bvalid) begin ok = 1; r = s_bresp; end
      step();
    end
    chk("b_response", ok, 1);
  endtask

  task automatic err_pair();
    s_araddr = 32'h2000_0000; s_arvalid = 1;
    s_awaddr = 32'h3000_0000; s_wdata = '0; s_wstrb = '0; s_awvalid = 1; s_wvalid = 1;
    step();
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    step();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0] r;
    int w;
    rst_n = 0;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 1;
    s_araddr = '0; s_arvalid = 0; s_rready = 1;
    map_start = '{32'h0000_0000, 32'h0010_0000, 32'h1A10_0000, 32'h0};
    map_end = '{32'h000F_FFFF, 32'h001F_FFFF, 32'h1A11_FFFF, 32'h0};
    map_en = '{1, 1, 1, 0};
    repeat (3) step();
    @(negedge clk);
    chk("rst_arready", s_arready, 0);
    chk("rst_awready", s_awready, 0);
    chk("rst_cnt", decerr_cnt, 0);
    step();
    rst_n = 1;
    step();

    // Mapped read to slave 1
    rd_start(32'h0010_0004);
    @(negedge clk);
    $display("read 0x00100004: m_arvalid=%b one cycle after accept", m_arvalid);
    chk("t1_arvalid", m_arvalid, 4'b0010);
    step();
    rd_finish(d, r, w);
    $display("read 0x00100004: data=0x%08h resp=%0d", d, r);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", r, 2'b00);

    // Unmapped read
    rd_start(32'h2000_0000);
    rd_finish(d, r, w);
    $display("read 0x20000000: data=0x%08h resp=%0d after %0d cycle(s)", d, r, w);
    chk("t2_rresp", r, 2'b11);
    chk("t2_rdata", d, 32'h0);
    chk("t2_latency", w, 1);
    @(negedge clk);
    chk("t2_cnt", decerr_cnt, 1);
    step();

    // Write to slave 2 with AW accepted 3 cycles before W
    w_lat[2] = 3;
    wr_start(32'h1A10_0008, 32'h5A, 4'hF);
    wr_finish(r);
    $display("write 0x1A100008: bresp=%0d aw->w gap=%0d", r, w_hs_cyc - aw_hs_cyc);
    chk("t3_bresp", r, 2'b00);
    chk("t3_gap", w_hs_cyc - aw_hs_cyc, 3);
    w_lat[2] = 0;

    // Overlapped map; map change during data phase must not reroute
    map_en[1] = 0;
    map_end[0] = 32'h001F_FFFF;
    step();
    s_rready = 0;
    rd_start(32'h0010_0000);
    step(); step();
    map_en[0] = 0; map_en[1] = 1;
    step(); step();
    rd_finish(d, r, w);
    $display("read 0x00100000 (remapped mid-flight): data=0x%08h resp=%0d", d, r);
    chk("t4_rdata", d, 32'h0000_1000);
    chk("t4_rresp", r, 2'b00);
    map_en = '{1, 1, 1, 0};
    map_end[0] = 32'h000F_FFFF;
    step();

    // Reset while read is in data phase and write is forwarding
    s_rready = 0;
    rd_start(32'h0000_0100);
    w_lat[2] = 50;
    wr_start(32'h1A10_0010, 32'h1234, 4'h3);
    step();
    rst_n = 0;
    step();
    @(negedge clk);
    $display("reset mid-flight: m_arvalid=%b m_awvalid=%b m_wvalid=%b cnt=%0d", m_arvalid, m_awvalid, m_wvalid, decerr_cnt);
    chk("t5_arvalid", m_arvalid, 0);
    chk("t5_awvalid", m_awvalid, 0);
    chk("t5_wvalid", m_wvalid, 0);
    chk("t5_rvalid", s_rvalid, 0);
    chk("t5_bvalid", s_bvalid, 0);
    chk("t5_cnt", decerr_cnt, 0);
    step();
    rst_n = 1;
    w_lat[2] = 0;
    s_rready = 1;
    step();
    rd_start(32'h0000_0200);
    rd_finish(d, r, w);
    $display("read 0x00000200 after reset: data=0x%08h resp=%0d", d, r);
    chk("t5_rdata", d, 32'h0000_1000);
    chk("t5_rresp", r, 2'b00);

    // Concurrent DECERR pairs drive the counter into saturation
    for (int k = 0; k < 127; k++) err_pair();
    @(negedge clk);
    $display("after 127 concurrent DECERR pairs: cnt=0x%02h", decerr_cnt);
    chk("t6_cnt_fe", decerr_cnt, 8'hFE);
    step();
    err_pair();
    @(negedge clk);
    $display("after final concurrent pair: cnt=0x%02h", decerr_cnt);
    chk("t6_cnt_sat", decerr_cnt, 8'hFF);
    step();
    rd_start(32'h2000_0000);
    rd_finish(d, r, w);
    @(negedge clk);
    $display("extra DECERR at saturation: cnt=0x%02h", decerr_cnt);
    chk("t6_cnt_hold", decerr_cnt, 8'hFF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
